// File: rtl/fir_avg_pkg.sv
// Shared types and default sizes for the moving-average FIR frame sequencer.
package fir_avg_pkg;

  localparam int FIR_DIN_W    = 16;
  localparam int FIR_DOUT_W   = 24;
  localparam int FIR_TAPS_DEF = 8;
  localparam int FIR_CNT_W    = 16;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } fir_ctrl_state_t;

endpackage

// File: rtl/fir_avg_ctrl.sv
// Frame sequencer gating a clock-enabled moving-average FIR: clear, stream, flush tail.
// Optional build macro FIR_CTRL_WARMUP_MASK_EN suppresses the first TAPS-1 outputs of each frame.
module fir_avg_ctrl
  import fir_avg_pkg::*;
#(
  parameter int DIN_W  = FIR_DIN_W,
  parameter int DOUT_W = FIR_DOUT_W,
  parameter int TAPS   = FIR_TAPS_DEF,
  parameter int CNT_W  = FIR_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DIN_W-1:0]  s_data,
  input  logic                     s_last,
  output logic                     fir_ce,
  output logic signed [DIN_W-1:0]  fir_din,
  input  logic signed [DOUT_W-1:0] fir_dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DOUT_W-1:0] m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic [CNT_W-1:0]         out_cnt
);

  localparam int              TW       = $clog2(TAPS + 1);
  localparam logic [TW-1:0]   TAP_LAST = TW'(TAPS - 1);
  localparam logic [TW-1:0]   TAP_PEN  = TW'(TAPS - 2);
  localparam logic [TW-1:0]   TAP_ONE  = TW'(1);

  fir_ctrl_state_t state_q, state_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic                    slot_free;
  logic                    ce_c;
  logic signed [DIN_W-1:0] din_c;
  logic                    s_ready_c;
  logic                    emit_c;
  logic                    emit_g;
  logic                    last_c;
  logic                    clr_cnt;

  assign slot_free = !m_valid_q || m_ready;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    ce_c      = 1'b0;
    din_c     = '0;
    s_ready_c = 1'b0;
    emit_c    = 1'b0;
    last_c    = 1'b0;
    clr_cnt   = 1'b0;
    case (state_q)
      INIT: begin
        // Zero pulses purge the reset-less FIR history; no output slot involved.
        ce_c  = 1'b1;
        tap_d = tap_q + TAP_ONE;
        if (tap_q == TAP_LAST) begin
          tap_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE, RUN: begin
        s_ready_c = slot_free;
        if (s_valid && slot_free) begin
          ce_c   = 1'b1;
          din_c  = s_data;
          emit_c = 1'b1;
          if (state_q == IDLE) begin
            clr_cnt = 1'b1;
            state_d = RUN;
          end
          if (s_last) begin
            tap_d   = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          ce_c  = 1'b1;
          tap_d = tap_q + TAP_ONE;
          if (tap_q == TAP_LAST) begin
            // Final zero pulse only empties the FIR; its result is dropped.
            tap_d   = '0;
            state_d = IDLE;
          end else begin
            emit_c = 1'b1;
            last_c = (tap_q == TAP_PEN);
          end
        end
      end
      default: begin
        state_d = INIT;
        tap_d   = '0;
      end
    endcase
  end

`ifdef FIR_CTRL_WARMUP_MASK_EN
  logic [TW-1:0] warm_q, warm_d;
  logic [TW-1:0] warm_prior;

  // Counts pulses already applied in this frame, saturating once the window is full.
  always_comb begin
    warm_prior = clr_cnt ? '0 : warm_q;
    warm_d     = warm_q;
    emit_g     = emit_c && (warm_prior == TAP_LAST);
    if (ce_c && (state_q != INIT)) begin
      warm_d = (warm_prior == TAP_LAST) ? warm_prior : warm_prior + TAP_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q <= '0;
    end else begin
      warm_q <= warm_d;
    end
  end
`else
  assign emit_g = emit_c;
`endif

  always_comb begin
    out_cnt_d = (clr_cnt ? '0 : out_cnt_q) + {{(CNT_W-1){1'b0}}, emit_g};
    m_valid_d = emit_g || (m_valid_q && !m_ready);
    if (emit_g) begin
      m_last_d = last_c;
    end else if (m_ready) begin
      m_last_d = 1'b0;
    end else begin
      m_last_d = m_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      tap_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // The FIR only advances on fir_ce, so its registered output is stable while the slot is held.
  assign fir_ce  = ce_c && rst_n;
  assign fir_din = rst_n ? din_c : '0;
  assign s_ready = s_ready_c;
  assign m_valid = m_valid_q;
  assign m_data  = m_valid_q ? fir_dout : '0;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);
  assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_fir_avg_ctrl.sv
// Self-checking bench: controller paired with a behavioural clock-enabled moving-sum FIR.
module tb_fir_avg_ctrl;

  localparam int DIN_W  = 16;
  localparam int DOUT_W = 24;
  localparam int TAPS   = 8;
  localparam int CNT_W  = 16;
`ifdef FIR_CTRL_WARMUP_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DIN_W-1:0]  s_data;
  logic                     s_last;
  logic                     fir_ce;
  logic signed [DIN_W-1:0]  fir_din;
  logic signed [DOUT_W-1:0] fir_dout;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DOUT_W-1:0] m_data;
  logic                     m_last;
  logic                     busy;
  logic [CNT_W-1:0]         out_cnt;

  always #5 clk = ~clk;

  fir_avg_ctrl #(
    .DIN_W (DIN_W),
    .DOUT_W(DOUT_W),
    .TAPS  (TAPS),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .fir_ce  (fir_ce),
    .fir_din (fir_din),
    .fir_dout(fir_dout),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy),
    .out_cnt (out_cnt)
  );

  // Reset-less FIR: history starts as garbage so the clearing pulses matter.
  logic signed [DIN_W-1:0] fir_hist [TAPS];
  logic                    fir_seeded = 1'b0;

  function automatic logic signed [DOUT_W-1:0] window_sum(input logic signed [DIN_W-1:0] din);
    int acc;
    acc = din;
    for (int i = 0; i < TAPS - 1; i++) acc += fir_hist[i];
    return DOUT_W'(acc);
  endfunction

  always @(posedge clk) begin
    if (!fir_seeded) begin
      for (int i = 0; i < TAPS; i++) fir_hist[i] <= DIN_W'(777 + 3 * i);
      fir_dout   <= DOUT_W'(999);
      fir_seeded <= 1'b1;
    end else if (fir_ce) begin
      for (int i = TAPS - 1; i > 0; i--) fir_hist[i] <= fir_hist[i-1];
      fir_hist[0] <= fir_din;
      fir_dout    <= window_sum(fir_din);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Sink side: drives m_ready, records handshakes, checks hold and slot rules.
  int ready_mode = 0;
  int rx_d[$];
  bit rx_l[$];
  int rx_c[$];

  initial begin
    bit hold;
    bit tog;
    longint hold_d;
    bit hold_l;
    hold   = 1'b0;
    tog    = 1'b0;
    hold_d = 0;
    hold_l = 1'b0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin tog = ~tog; m_ready = tog; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, hold_d);
          chk("hold_last", m_last, hold_l);
        end
        if (m_valid && !m_ready) chk("ce_slot_full", fir_ce, 0);
        if (fir_ce) chk("fir_din", fir_din, (s_valid && s_ready) ? longint'(s_data) : 0);
        if (s_valid && s_ready) chk("ce_on_accept", fir_ce, 1);
        if (m_valid && m_ready) begin
          rx_d.push_back(int'(m_data));
          rx_l.push_back(m_last);
          rx_c.push_back(cyc);
        end
        hold   = m_valid && !m_ready;
        hold_d = m_data;
        hold_l = m_last;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 1000000", $time);
    $fatal(1, "watchdog");
  end

  int acc_cyc[$];

  task automatic drive_stream(input int xs[$], input bit ls[$]);
    bit got;
    acc_cyc.delete();
    foreach (xs[i]) begin
      got     = 1'b0;
      s_valid = 1'b1;
      s_data  = DIN_W'(xs[i]);
      s_last  = ls[i];
      for (int w = 0; w < 400 && !got; w++) begin
        #1;
        if (s_ready) begin
          got = 1'b1;
          acc_cyc.push_back(cyc);
        end
        @(negedge clk);
      end
      if (!got) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_drain(input int n_exp);
    bit done;
    done = 1'b0;
    for (int w = 0; w < 3000 && !done; w++) begin
      if (rx_d.size() >= n_exp && !busy) done = 1'b1;
      else @(negedge clk);
    end
    chk("drain_done", done, 1);
    repeat (4) @(negedge clk);
  endtask

  // Reference: each frame is a full convolution with a length-TAPS box of ones.
  int exp_d[$];
  bit exp_l[$];
  int exp_oc;

  task automatic ref_model(input int xs[$], input bit ls[$]);
    int fr[$];
    int n;
    int s;
    exp_d.delete();
    exp_l.delete();
    exp_oc = 0;
    foreach (xs[i]) begin
      fr.push_back(xs[i]);
      if (ls[i]) begin
        n = fr.size();
        exp_oc = 0;
        for (int k = 0; k <= n + TAPS - 2; k++) begin
          s = 0;
          for (int j = 0; j < n; j++) if (j <= k && k - j < TAPS) s += fr[j];
          if (!(MASK && k < TAPS - 1)) begin
            exp_d.push_back(s);
            exp_l.push_back(k == n + TAPS - 2);
            exp_oc++;
          end
        end
        fr.delete();
      end
    end
  endtask

  task automatic run_check(input string tag, input int xs[$], input bit ls[$], input int mode,
                           input int ed[$], input bit el[$], input int oc);
    ready_mode = mode;
    rx_d.delete();
    rx_l.delete();
    rx_c.delete();
    drive_stream(xs, ls);
    wait_drain(ed.size());
    chk({tag, "_count"}, rx_d.size(), ed.size());
    for (int i = 0; i < ed.size() && i < rx_d.size(); i++) begin
      $display("%s out[%0d] data=%0d last=%0d", tag, i, rx_d[i], rx_l[i]);
      chk({tag, "_data"}, rx_d[i], ed[i]);
      chk({tag, "_last"}, rx_l[i], el[i]);
    end
    chk({tag, "_out_cnt"}, out_cnt, oc % (1 << CNT_W));
    if (mode == 0) begin
      for (int i = 1; i < acc_cyc.size(); i++)
        chk({tag, "_accept_gap"}, acc_cyc[i] - acc_cyc[i-1], ls[i-1] ? TAPS + 1 : 1);
      if (rx_c.size() > 0 && acc_cyc.size() > 0)
        chk({tag, "_latency"}, rx_c[0] - acc_cyc[0], MASK ? TAPS : 1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_fir_ce"}, fir_ce, 0);
    chk({tag, "_fir_din"}, fir_din, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_out_cnt"}, out_cnt, 0);
  endtask

  // Called on the negedge where rst_n has just been released.
  task automatic check_init(input string tag);
    int pulses;
    int last_pulse;
    bit bad_rdy;
    bit bad_din;
    pulses     = 0;
    last_pulse = -1;
    bad_rdy    = 1'b0;
    bad_din    = 1'b0;
    for (int c = 0; c < TAPS + 2; c++) begin
      #1;
      if (c == 0) chk({tag, "_busy_init"}, busy, 1);
      if (fir_ce) begin
        pulses++;
        last_pulse = c;
        if (fir_din != 0) bad_din = 1'b1;
      end
      if (c < TAPS && s_ready) bad_rdy = 1'b1;
      @(negedge clk);
    end
    $display("%s: %0d init pulses, last at cycle %0d", tag, pulses, last_pulse);
    chk({tag, "_pulses"}, pulses, TAPS);
    chk({tag, "_last_pulse"}, last_pulse, TAPS - 1);
    chk({tag, "_s_ready_low"}, bad_rdy, 0);
    chk({tag, "_din_zero"}, bad_din, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  typedef struct {
    int n;
    int x[4];
    bit l[4];
    int mode;
    int ne;
    int e[20];
    bit el[20];
    int oc;
  } vec_t;

  vec_t tbl[3];

  task automatic set_vec(input int idx, input int xq[$], input bit lq[$], input int mode,
                         input int eq[$], input bit elq[$], input int oc);
    tbl[idx].n    = xq.size();
    tbl[idx].mode = mode;
    tbl[idx].ne   = eq.size();
    tbl[idx].oc   = oc;
    for (int k = 0; k < 4; k++) begin
      tbl[idx].x[k] = (k < xq.size()) ? xq[k] : 0;
      tbl[idx].l[k] = (k < lq.size()) ? lq[k] : 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      tbl[idx].e[k]  = (k < eq.size()) ? eq[k] : 0;
      tbl[idx].el[k] = (k < elq.size()) ? elq[k] : 1'b0;
    end
  endtask

  task automatic run_vec(input int t, input string tag);
    int xs[$];
    bit ls[$];
    int ed[$];
    bit el[$];
    for (int k = 0; k < tbl[t].n; k++) begin
      xs.push_back(tbl[t].x[k]);
      ls.push_back(tbl[t].l[k]);
    end
    for (int k = 0; k < tbl[t].ne; k++) begin
      ed.push_back(tbl[t].e[k]);
      el.push_back(tbl[t].el[k]);
    end
    run_check(tag, xs, ls, tbl[t].mode, ed, el, tbl[t].oc);
  endtask

  initial begin
    int xs[$];
    bit ls[$];
    int nf;
    int len;
    int mode;
    logic signed [15:0] r;

`ifdef FIR_CTRL_WARMUP_MASK_EN
    set_vec(0, '{8, 16, 24}, '{0, 0, 1}, 0, '{48, 40, 24}, '{0, 0, 1}, 3);
    set_vec(1, '{8, 16, 24}, '{0, 0, 1}, 1, '{48, 40, 24}, '{0, 0, 1}, 3);
    set_vec(2, '{100, -65, -105}, '{1, 0, 1}, 0, '{100, -170, -105}, '{1, 0, 1}, 2);
`else
    set_vec(0, '{8, 16, 24}, '{0, 0, 1}, 0,
            '{8, 24, 48, 48, 48, 48, 48, 48, 40, 24}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 10);
    set_vec(1, '{8, 16, 24}, '{0, 0, 1}, 1,
            '{8, 24, 48, 48, 48, 48, 48, 48, 40, 24}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 10);
    set_vec(2, '{100, -65, -105}, '{1, 0, 1}, 0,
            '{100, 100, 100, 100, 100, 100, 100, 100,
              -65, -170, -170, -170, -170, -170, -170, -170, -105},
            '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 9);
`endif

    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_init("init");

    run_vec(0, "basic");
    run_vec(1, "backpressure");
    run_vec(2, "back2back");

    // Reset in the middle of a frame, then confirm the FIR was cleared again.
    ready_mode = 0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = DIN_W'(500 + 100 * k);
      s_last  = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("midrun_busy", busy, 1);
    chk("midrun_out_cnt", out_cnt, MASK ? 0 : 4);
    chk("midrun_m_valid", m_valid, MASK ? 0 : 1);
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_init("reinit");
    run_vec(0, "after_reset");

    for (int t = 0; t < 8; t++) begin
      xs.delete();
      ls.delete();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 10);
        for (int k = 0; k < len; k++) begin
          r = 16'($urandom);
          xs.push_back(int'(r));
          ls.push_back(k == len - 1);
        end
      end
      mode = $urandom_range(0, 2);
      ref_model(xs, ls);
      $display("random stream %0d: %0d samples, %0d frames, ready mode %0d", t, xs.size(), nf, mode);
      run_check("random", xs, ls, mode, exp_d, exp_l, exp_oc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
